// File: rtl/qpl_pkg.sv
// QPL shared definitions: word widths and the placement of the
// user-data and port-ID fields inside request and reply words.
package qpl_pkg;

  function automatic int id_w(input int ports);
    return (ports > 1) ? $clog2(ports) : 1;
  endfunction

  function automatic int req_w(
    input int udata_w,
    input int block_d,
    input int line_byte
  );
    return udata_w + $clog2(block_d * line_byte) + 1;
  endfunction

  function automatic int rep_w(
    input int udata_w,
    input int block_d
  );
    return udata_w + 2 * $clog2(block_d) + 1;
  endfunction

  function automatic int cnt_w(input int max_outst);
    return $clog2(max_outst + 1);
  endfunction

  // user data is the MSB field; the port ID is its low bits
  function automatic int ud_lsb(
    input int word_w,
    input int udata_w
  );
    return word_w - udata_w;
  endfunction

  function automatic int id_lsb(
    input int word_w,
    input int udata_w
  );
    return ud_lsb(word_w, udata_w);
  endfunction

  // one extra user-data bit above the ID flags an out-of-range ID
  function automatic bit has_chk(
    input int udata_w,
    input int ports
  );
    return udata_w > id_w(ports);
  endfunction

endpackage

// File: rtl/qpl_rr_arb.sv
// Round-robin arbiter: eligibility mask, first-at-or-after-pointer
// grant and the priority pointer register.
module qpl_rr_arb
  import qpl_pkg::*;
#(
  parameter int PORTS = 4,
  parameter int ID_W  = id_w(PORTS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PORTS-1:0] vld,
  input  logic [PORTS-1:0] full,
  input  logic             take,
  output logic [PORTS-1:0] gnt,
  output logic [ID_W-1:0]  idx,
  output logic             any
);

  logic [PORTS-1:0] elig;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  cand;

  assign elig = vld & ~full;

  // PORTS is a power of two, so ID_W-bit addition wraps naturally
  always_comb begin
    any  = 1'b0;
    idx  = ptr;
    cand = ptr;
    gnt  = '0;
    for (int i = 0; i < PORTS; i++) begin
      cand = ptr + ID_W'(i);
      if (!any && elig[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
    if (any) gnt[idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (take && any) begin
      ptr <= idx + ID_W'(1);
    end
  end

endmodule

// File: rtl/qpl_req_arbiter.sv
// QPL requester arbiter: merges per-port alloc/dealloc requests to the
// manager and routes replies back by the port ID in user data.
module qpl_req_arbiter
  import qpl_pkg::*;
#(
  parameter int PORTS     = 4,
  parameter int UDATA_W   = 8,
  parameter int LINE_BYTE = 64,
  parameter int BLOCK_D   = 8,
  parameter int MAX_OUTST = 3,
  localparam int ID_W  = id_w(PORTS),
  localparam int REQ_W = req_w(UDATA_W, BLOCK_D, LINE_BYTE),
  localparam int REP_W = rep_w(UDATA_W, BLOCK_D)
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [PORTS-1:0]            i_req_alloc_vld,
  input  logic [PORTS-1:0]            i_req_dealloc_vld,
  input  logic [PORTS-1:0][REQ_W-1:0] i_req_alloc_data,
  input  logic [PORTS-1:0][REP_W-1:0] i_req_dealloc_data,
  output logic [PORTS-1:0]            o_req_alloc_rdy,
  output logic [PORTS-1:0]            o_req_dealloc_rdy,
  output logic                        o_mreq_alloc_vld,
  output logic                        o_mreq_dealloc_vld,
  output logic [REQ_W-1:0]            o_mreq_alloc_data,
  output logic [REP_W-1:0]            o_mreq_dealloc_data,
  input  logic                        i_mreq_alloc_rdy,
  input  logic                        i_mreq_dealloc_rdy,
  input  logic                        i_mrep_alloc_vld,
  input  logic                        i_mrep_dealloc_vld,
  input  logic [REP_W-1:0]            i_mrep_alloc_data,
  input  logic [REP_W-1:0]            i_mrep_dealloc_data,
  output logic                        o_mrep_alloc_rdy,
  output logic                        o_mrep_dealloc_rdy,
  output logic [PORTS-1:0]            o_rep_alloc_vld,
  output logic [PORTS-1:0]            o_rep_dealloc_vld,
  output logic [REP_W-1:0]            o_rep_alloc_data,
  output logic [REP_W-1:0]            o_rep_dealloc_data,
  input  logic [PORTS-1:0]            i_rep_alloc_rdy,
  input  logic [PORTS-1:0]            i_rep_dealloc_rdy,
  output logic                        o_err
);

  localparam int CNT_W = cnt_w(MAX_OUTST);
  localparam int RQ_ID = id_lsb(REQ_W, UDATA_W);
  localparam int RP_ID = id_lsb(REP_W, UDATA_W);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTST);

  logic [PORTS-1:0]            a_full, a_zero, a_gnt, a_hs;
  logic [PORTS-1:0]            d_full, d_zero, d_gnt, d_hs;
  logic [PORTS-1:0][CNT_W-1:0] a_cnt, d_cnt;
  logic [ID_W-1:0]             a_idx, d_idx;
  logic                        a_any, d_any;
  logic                        a_take, d_take;
  logic [REQ_W-1:0]            a_mux;
  logic [REP_W-1:0]            d_mux;
  logic [ID_W-1:0]             ra_id, rd_id;
  logic                        ra_bad, rd_bad;
  logic                        err_set;

  // request side: a slot opens when the register is empty or draining
  assign a_take = !i_rst && (!o_mreq_alloc_vld || i_mreq_alloc_rdy);
  assign d_take = !i_rst && (!o_mreq_dealloc_vld || i_mreq_dealloc_rdy);

  qpl_rr_arb #(
    .PORTS(PORTS),
    .ID_W (ID_W)
  ) u_arb_alloc (
    .clk (i_clk),
    .rst (i_rst),
    .vld (i_req_alloc_vld),
    .full(a_full),
    .take(a_take),
    .gnt (a_gnt),
    .idx (a_idx),
    .any (a_any)
  );

  qpl_rr_arb #(
    .PORTS(PORTS),
    .ID_W (ID_W)
  ) u_arb_dealloc (
    .clk (i_clk),
    .rst (i_rst),
    .vld (i_req_dealloc_vld),
    .full(d_full),
    .take(d_take),
    .gnt (d_gnt),
    .idx (d_idx),
    .any (d_any)
  );

  assign o_req_alloc_rdy   = a_gnt & {PORTS{a_take}};
  assign o_req_dealloc_rdy = d_gnt & {PORTS{d_take}};

  always_comb begin
    a_mux = i_req_alloc_data[a_idx];
    a_mux[RQ_ID +: ID_W] = a_idx;
    d_mux = i_req_dealloc_data[d_idx];
    d_mux[RP_ID +: ID_W] = d_idx;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_mreq_alloc_vld    <= 1'b0;
      o_mreq_alloc_data   <= '0;
      o_mreq_dealloc_vld  <= 1'b0;
      o_mreq_dealloc_data <= '0;
    end else begin
      if (a_take) begin
        o_mreq_alloc_vld <= a_any;
        if (a_any) o_mreq_alloc_data <= a_mux;
      end
      if (d_take) begin
        o_mreq_dealloc_vld <= d_any;
        if (d_any) o_mreq_dealloc_data <= d_mux;
      end
    end
  end

  // reply side: purely combinational routing by ID
  assign ra_id = i_mrep_alloc_data[RP_ID +: ID_W];
  assign rd_id = i_mrep_dealloc_data[RP_ID +: ID_W];

  generate
    if (has_chk(UDATA_W, PORTS)) begin : g_chk
      assign ra_bad = i_mrep_alloc_data[RP_ID + ID_W];
      assign rd_bad = i_mrep_dealloc_data[RP_ID + ID_W];
    end else begin : g_nochk
      assign ra_bad = 1'b0;
      assign rd_bad = 1'b0;
    end
  endgenerate

  always_comb begin
    o_rep_alloc_vld   = '0;
    o_rep_dealloc_vld = '0;
    if (!i_rst && i_mrep_alloc_vld && !ra_bad)
      o_rep_alloc_vld[ra_id] = 1'b1;
    if (!i_rst && i_mrep_dealloc_vld && !rd_bad)
      o_rep_dealloc_vld[rd_id] = 1'b1;
  end

  // bad-ID replies are swallowed so the manager never stalls on them
  assign o_mrep_alloc_rdy   = !i_rst &&
                              (ra_bad || i_rep_alloc_rdy[ra_id]);
  assign o_mrep_dealloc_rdy = !i_rst &&
                              (rd_bad || i_rep_dealloc_rdy[rd_id]);
  assign o_rep_alloc_data   = i_mrep_alloc_data;
  assign o_rep_dealloc_data = i_mrep_dealloc_data;

  assign a_hs = o_rep_alloc_vld & i_rep_alloc_rdy;
  assign d_hs = o_rep_dealloc_vld & i_rep_dealloc_rdy;

  // outstanding counters
  always_comb begin
    a_full = '0;
    a_zero = '0;
    d_full = '0;
    d_zero = '0;
    for (int p = 0; p < PORTS; p++) begin
      a_full[p] = a_cnt[p] >= CNT_MAX;
      a_zero[p] = a_cnt[p] == '0;
      d_full[p] = d_cnt[p] >= CNT_MAX;
      d_zero[p] = d_cnt[p] == '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      a_cnt <= '0;
      d_cnt <= '0;
    end else begin
      for (int p = 0; p < PORTS; p++) begin
        unique case ({o_req_alloc_rdy[p], a_hs[p]})
          2'b10:   a_cnt[p] <= a_cnt[p] + 1'b1;
          2'b01:   if (!a_zero[p]) a_cnt[p] <= a_cnt[p] - 1'b1;
          default: ;
        endcase
        unique case ({o_req_dealloc_rdy[p], d_hs[p]})
          2'b10:   d_cnt[p] <= d_cnt[p] + 1'b1;
          2'b01:   if (!d_zero[p]) d_cnt[p] <= d_cnt[p] - 1'b1;
          default: ;
        endcase
      end
    end
  end

  // sticky error: out-of-range reply ID or reply with nothing outstanding
  assign err_set = (i_mrep_alloc_vld && ra_bad) ||
                   (i_mrep_dealloc_vld && rd_bad) ||
                   (|(a_hs & a_zero)) ||
                   (|(d_hs & d_zero));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_err <= 1'b0;
    end else if (err_set) begin
      o_err <= 1'b1;
    end
  end

endmodule
